// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order requests to a
// variable-latency instruction memory, and buffers returned instructions in a
// DEPTH-entry prefetch queue feeding decode over a valid/ready handshake.
// Redirects (exception > branch > jump) flush the queue and discard any
// responses that were already in flight on the wrong path.
module if_fetch_queue #(
  parameter int               XLEN        = 32,
  parameter int               DEPTH       = 4,
  parameter logic [XLEN-1:0]  RESET_PC    = '0,
  parameter int               INSTR_BYTES = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_pc_write,
  input  logic            i_exc,
  input  logic [XLEN-1:0] i_exc_addr,
  input  logic            i_branch_taken,
  input  logic [XLEN-1:0] i_branch_addr,
  input  logic            i_jump,
  input  logic [XLEN-1:0] i_jump_addr,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_rvalid,
  input  logic [XLEN-1:0] i_imem_rdata,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_next_pc
);

  localparam int              PW  = $clog2(DEPTH);
  localparam int              CW  = PW + 1;
  localparam logic [XLEN-1:0] INC = XLEN'(INSTR_BYTES);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [CW-1:0]   count;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;

  // Queue storage holds data only; it is never reset, outputs are gated instead.
  logic [XLEN-1:0] instr_mem [DEPTH];
  logic [XLEN-1:0] npc_mem   [DEPTH];

  logic            redir;
  logic [XLEN-1:0] redir_addr;
  logic [CW:0]     credit_used;
  logic            rsp_ok;
  logic            drop_hit;
  logic            push;
  logic            pop;

  // Fixed-priority redirect target selection: exception, then branch, then jump.
  always_comb begin
    redir      = i_exc | i_branch_taken | i_jump;
    redir_addr = i_jump_addr;
    if (i_exc)               redir_addr = i_exc_addr;
    else if (i_branch_taken) redir_addr = i_branch_addr;
  end

  // Queue slots plus in-flight requests never exceed DEPTH, so a push always fits.
  assign credit_used = {1'b0, count} + {1'b0, outstanding};
  assign o_imem_req  = i_rst_n & i_pc_write & ~redir & (credit_used < (CW+1)'(DEPTH));
  assign o_imem_addr = fetch_pc;

  // A response with nothing outstanding is spurious and is ignored entirely.
  assign rsp_ok   = i_imem_rvalid & (outstanding != '0);
  assign drop_hit = rsp_ok & (drop_cnt != '0);
  assign push     = rsp_ok & ~redir & (drop_cnt == '0);
  assign pop      = o_valid & i_ready;

  assign o_valid   = (count != '0);
  assign o_instr   = o_valid ? instr_mem[rd_ptr] : '0;
  assign o_next_pc = o_valid ? npc_mem[rd_ptr]   : '0;

  // Fetch/response PCs: both jump to the redirect target, else advance on issue/push.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
    end else if (redir) begin
      fetch_pc <= redir_addr;
      resp_pc  <= redir_addr;
    end else begin
      if (o_imem_req) fetch_pc <= fetch_pc + INC;
      if (push)       resp_pc  <= resp_pc + INC;
    end
  end

  // Outstanding and drop counters; a redirect marks every in-flight response for drop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(o_imem_req) - CW'(rsp_ok);
      if (redir)         drop_cnt <= outstanding - CW'(rsp_ok);
      else if (drop_hit) drop_cnt <= drop_cnt - CW'(1);
    end
  end

  // Queue occupancy and pointers; a redirect empties the queue after any pop this cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (redir) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      count <= count + CW'(push) - CW'(pop);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Queue data write: instruction plus the PC of the following instruction.
  always_ff @(posedge i_clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= i_imem_rdata;
      npc_mem[wr_ptr]   <= resp_pc + INC;
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboard bench for if_fetch_queue: directed scenarios push the expected
// delivered PCs into a queue; a monitor pops and compares on every handshake
// and checks every request address. A small in-order memory model with a
// configurable latency answers requests.
module tb_if_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_write = 1'b0;
  logic        exc = 1'b0, branch = 1'b0, jump = 1'b0;
  logic [31:0] exc_addr = '0, br_addr = '0, j_addr = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic        o_valid;
  logic        ready = 1'b0;
  logic [31:0] o_instr;
  logic [31:0] o_next_pc;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int lat = 1;
  int req_cnt = 0, pop_cnt = 0;
  int first_req_cyc = 0, first_pop_cyc = 0, last_pop_cyc = 0;
  logic [31:0] exp_req_addr = '0;
  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];
  logic [31:0] exp_q[$];

  if_fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0), .INSTR_BYTES(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_pc_write(pc_write),
    .i_exc(exc), .i_exc_addr(exc_addr),
    .i_branch_taken(branch), .i_branch_addr(br_addr),
    .i_jump(jump), .i_jump_addr(j_addr),
    .o_imem_req(imem_req), .o_imem_addr(imem_addr),
    .i_imem_rvalid(rvalid), .i_imem_rdata(rdata),
    .o_valid(o_valid), .i_ready(ready),
    .o_instr(o_instr), .o_next_pc(o_next_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hA5A5A5A5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  // Advance to the next negedge and drive the memory response for that cycle.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      mem_addr_q.delete();
      mem_due_q.delete();
      rvalid = 1'b0;
      rdata  = '0;
    end else if (mem_due_q.size() > 0 && mem_due_q[0] <= cyc) begin
      rvalid = 1'b1;
      rdata  = instr_of(mem_addr_q[0]);
      void'(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
    end else begin
      rvalid = 1'b0;
      rdata  = '0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; pc_write = 1'b0; ready = 1'b0;
    exc = 1'b0; branch = 1'b0; jump = 1'b0;
    cycle();
    cycle();
    exp_q.delete();
    exp_req_addr = '0;
    req_cnt = 0; pop_cnt = 0;
  endtask

  task automatic drain(input string name, input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      cycle();
      n++;
    end
    ready = 1'b0;
    pc_write = 1'b0;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: %0d entries left, expected 0", name, exp_q.size());
    end
  endtask

  // Monitor: check each request address and each delivered instruction.
  always @(negedge clk) begin : mon
    logic [31:0] a;
    #2;
    if (rst_n === 1'b1) begin
      if (imem_req) begin
        chk("req_addr", imem_addr, exp_req_addr);
        exp_req_addr = imem_addr + 32'd4;
        mem_addr_q.push_back(imem_addr);
        mem_due_q.push_back(cyc + lat);
        if (req_cnt == 0) first_req_cyc = cyc;
        req_cnt++;
      end
      if (o_valid && ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL pop_unexpected: got next_pc %h, expected no delivery", o_next_pc);
        end else begin
          a = exp_q.pop_front();
          chk("instr", o_instr, instr_of(a));
          chk("next_pc", o_next_pc, a + 32'd4);
        end
        if (pop_cnt == 0) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
        pop_cnt++;
      end
    end
  end

  initial begin
    // Reset state, with pc_write high to show the request is held off.
    do_reset();
    pc_write = 1'b1;
    cycle();
    #3;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_instr", o_instr, 32'd0);
    chk("rst_next_pc", o_next_pc, 32'd0);

    // Streaming at L=1: one instruction per cycle, no gaps.
    do_reset();
    lat = 1; ready = 1'b1; pc_write = 1'b1;
    push_exp(32'h0, 40);
    cycle();
    rst_n = 1'b1;
    drain("stream", 100);
    chk("stream_latency", 32'(first_pop_cyc - first_req_cyc), 32'd2);
    chk("stream_gapless", 32'(last_pop_cyc - first_pop_cyc), 32'd39);

    // Decode stalled 10 cycles: credit caps requests at 4, head held.
    do_reset();
    lat = 1; ready = 1'b0; pc_write = 1'b1;
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) cycle();
    #3;
    chk("full_req_cnt", 32'(req_cnt), 32'd4);
    chk("full_req_off", 32'(imem_req), 32'd0);
    chk("full_valid", 32'(o_valid), 32'd1);
    chk("full_head_instr", o_instr, instr_of(32'h0));
    chk("full_head_npc", o_next_pc, 32'h4);
    push_exp(32'h0, 10);
    cycle();
    ready = 1'b1;
    drain("full", 60);

    // L=3, three in flight, branch to 0x100: all three late responses dropped.
    do_reset();
    lat = 3; ready = 1'b1; pc_write = 1'b1;
    cycle();
    rst_n = 1'b1;
    cycle();
    cycle();
    cycle();
    branch = 1'b1; br_addr = 32'h100;
    exp_req_addr = 32'h100;
    push_exp(32'h100, 6);
    #3;
    chk("branch_req_off", 32'(imem_req), 32'd0);
    cycle();
    branch = 1'b0;
    #3;
    chk("branch_valid_low", 32'(o_valid), 32'd0);
    drain("branch", 60);

    // Simultaneous exception/branch/jump: exception target wins.
    do_reset();
    lat = 1; ready = 1'b1; pc_write = 1'b1;
    push_exp(32'h0, 2);
    cycle();
    rst_n = 1'b1;
    cycle();
    cycle();
    cycle();
    exc = 1'b1; exc_addr = 32'h80;
    branch = 1'b1; br_addr = 32'h200;
    jump = 1'b1; j_addr = 32'h300;
    exp_req_addr = 32'h80;
    push_exp(32'h80, 5);
    cycle();
    exc = 1'b0; branch = 1'b0; jump = 1'b0;
    drain("prio", 60);

    // pc_write low for 5 cycles with 2 outstanding: both land, fetch resumes at 8.
    do_reset();
    lat = 3; ready = 1'b1; pc_write = 1'b1;
    push_exp(32'h0, 6);
    cycle();
    rst_n = 1'b1;
    cycle();
    cycle();
    pc_write = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #3;
      chk("stall_req_off", 32'(imem_req), 32'd0);
      cycle();
    end
    chk("stall_req_cnt", 32'(req_cnt), 32'd2);
    chk("stall_delivered", 32'(pop_cnt), 32'd2);
    pc_write = 1'b1;
    drain("stall", 60);

    // Asynchronous reset mid-stream with the queue partly full.
    do_reset();
    lat = 1; ready = 1'b0; pc_write = 1'b1;
    cycle();
    rst_n = 1'b1;
    cycle();
    cycle();
    cycle();
    #3;
    chk("midrst_pre_valid", 32'(o_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(o_valid), 32'd0);
    chk("midrst_req", 32'(imem_req), 32'd0);
    chk("midrst_instr", o_instr, 32'd0);
    chk("midrst_npc", o_next_pc, 32'd0);
    cycle();
    cycle();
    exp_q.delete();
    exp_req_addr = 32'h0;
    req_cnt = 0; pop_cnt = 0;
    push_exp(32'h0, 3);
    ready = 1'b1;
    rst_n = 1'b1;
    drain("midrst", 40);

    // Spurious rvalid with nothing outstanding is ignored.
    do_reset();
    lat = 1; ready = 1'b1; pc_write = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
    rvalid = 1'b1; rdata = 32'hDEADBEEF;
    cycle();
    #3;
    chk("spurious_valid", 32'(o_valid), 32'd0);
    cycle();
    pc_write = 1'b1;
    push_exp(32'h0, 3);
    drain("spurious", 40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

endmodule
